div_unit: RTL and testbench

Multi-cycle restoring divider for the EX stage of the 5-stage MIPS pipeline, executing DIV/DIVU into the HI/LO pair. It consumes operands from EX and produces `STALL_REQ_EX` for the stall controller, holding the pipeline while an iteration is in flight. It releases the stall on the single cycle in which the result is presented.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 164 ++++++++++++++++
 tb/tb_div_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the EX-stage multi-cycle divider.
//   div_state_e : divider FSM states
//   DIV_DATA_W  : default operand width
//   DIV_ITER    : restoring iterations for the default width
//   DIV_LO_LSB / DIV_HI_LSB : quotient (LO) / remainder (HI) split of RESULT
// Reset polarity constants live in defines.vh, not here.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITER   = DIV_DATA_W;
  localparam int DIV_LO_LSB = 0;
  localparam int DIV_HI_LSB = DIV_DATA_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BY_ZERO = 3'd1,
    ON      = 3'd2,
    DONE    = 3'd3,
    EARLY   = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// Ports:
//   i_rem  [W:0] : partial remainder before the step
//   i_bit        : next dividend bit shifted in (MSB first)
//   i_dvs  [W:0] : divisor magnitude
//   o_rem  [W:0] : partial remainder after the step
//   o_q          : quotient bit (1 = trial subtract did not borrow)
// -----------------------------------------------------------------------------
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0] i_rem,
  input  logic       i_bit,
  input  logic [W:0] i_dvs,
  output logic [W:0] o_rem,
  output logic       o_q
);

  logic [W:0] w_shift;

  // The compare uses the full shifted value; when it passes, the true
  // difference is below the divisor, so the W+1-bit wrap is exact.
  assign w_shift = {i_rem[W-1:0], i_bit};
  assign o_q     = ({i_rem, i_bit} >= {1'b0, i_dvs});
  assign o_rem   = o_q ? (w_shift - i_dvs) : w_shift;

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring divider for DIV/DIVU in EX, result into HI/LO.
// Ports:
//   CLK, RST (async, active-low)
//   START, SIGNED_DIV, DIVIDEND, DIVISOR : request from EX, held until READY
//   ANNUL        : flush, aborts any operation, priority over START
//   RESULT       : {remainder (HI), quotient (LO)}, zero unless READY
//   READY        : one-cycle result strobe
//   STALL_REQ_EX : START & ~READY & ~ANNUL to the stall controller
// Optional feature macro: DIV_EARLY_OUT_EN -- when |dividend| < |divisor|
// the result is produced through the one-cycle EARLY state.
//
// state   | meaning
// IDLE    | waiting for START
// BY_ZERO | divisor was zero, result forced to 0
// ON      | one restoring step per cycle
// EARLY   | |dividend| < |divisor|, remainder = dividend (early-out build)
// DONE    | READY=1, sign-corrected RESULT presented
// -----------------------------------------------------------------------------
module div_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SIGNED_DIV,
  input  logic [DATA_W-1:0]     DIVIDEND,
  input  logic [DATA_W-1:0]     DIVISOR,
  input  logic                  ANNUL,
  output logic [2*DATA_W-1:0]   RESULT,
  output logic                  READY,
  output logic                  STALL_REQ_EX
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W:0]   r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W:0]   r_dvs;
  logic              r_q_neg;
  logic              r_r_neg;

  logic              w_dvd_neg, w_dvs_neg, w_dvs_zero, w_accept;
  logic [DATA_W-1:0] w_dvd_mag;
  logic [DATA_W:0]   w_dvs_mag;
  logic [DATA_W:0]   w_step_rem;
  logic              w_step_q;
  logic [DATA_W-1:0] w_quo_fix, w_rem_fix;
  logic              w_unused_rem_msb;

  assign w_dvd_neg  = SIGNED_DIV & DIVIDEND[DATA_W-1];
  assign w_dvs_neg  = SIGNED_DIV & DIVISOR[DATA_W-1];
  assign w_dvs_zero = (DIVISOR == '0);
  assign w_accept   = (r_state == IDLE) & START & ~ANNUL;

  // The dividend magnitude of the most negative value is 2^(W-1), which
  // still fits unsigned in W bits; the divisor is kept in W+1 bits by
  // sign-extending before negation.
  assign w_dvd_mag = w_dvd_neg ? (-DIVIDEND) : DIVIDEND;
  assign w_dvs_mag = w_dvs_neg ? (-{DIVISOR[DATA_W-1], DIVISOR}) : {1'b0, DIVISOR};

`ifdef DIV_EARLY_OUT_EN
  logic w_small;
  assign w_small = ({1'b0, w_dvd_mag} < w_dvs_mag);
`endif

  div_step #(.W(DATA_W)) u_step (
    .i_rem (r_rem),
    .i_bit (r_quo[DATA_W-1]),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_dvs_zero) w_state_nxt = BY_ZERO;
`ifdef DIV_EARLY_OUT_EN
          else if (w_small) w_state_nxt = EARLY;
`endif
          else w_state_nxt = ON;
        end
      end
      BY_ZERO: w_state_nxt = DONE;
      EARLY:   w_state_nxt = DONE;
      ON:      if (r_cnt == CNT_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (ANNUL) w_state_nxt = IDLE;
  end

  // The quotient register starts as the dividend magnitude; its MSB feeds
  // each step and quotient bits fill in from the bottom.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (ANNUL) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
            if (w_dvs_zero) r_quo <= '0;
`ifdef DIV_EARLY_OUT_EN
            else if (w_small) begin
              r_quo <= '0;
              r_rem <= {1'b0, w_dvd_mag};
            end
`endif
          end
        end
        ON: begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[DATA_W-2:0], w_step_q};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The final remainder is below the divisor, so its top bit is always 0.
  assign w_unused_rem_msb = r_rem[DATA_W];

  assign w_quo_fix = r_q_neg ? (-r_quo) : r_quo;
  assign w_rem_fix = r_r_neg ? (-r_rem[DATA_W-1:0]) : r_rem[DATA_W-1:0];

  assign READY        = (r_state == DONE) & ~ANNUL;
  assign RESULT       = READY ? {w_rem_fix, w_quo_fix} : '0;
  assign STALL_REQ_EX = START & ~READY & ~ANNUL;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        SIGNED_DIV = 1'b0;
  logic [31:0] DIVIDEND = '0;
  logic [31:0] DIVISOR = '0;
  logic        ANNUL = 1'b0;
  logic [63:0] RESULT;
  logic        READY;
  logic        STALL_REQ_EX;

  div_unit #(.DATA_W(32)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .SIGNED_DIV   (SIGNED_DIV),
    .DIVIDEND     (DIVIDEND),
    .DIVISOR      (DIVISOR),
    .ANNUL        (ANNUL),
    .RESULT       (RESULT),
    .READY        (READY),
    .STALL_REQ_EX (STALL_REQ_EX)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard side: every READY must match the oldest outstanding divide.
  always @(negedge CLK) begin
    if (RST && READY) begin
      if (sb_q.size() == 0) begin
        check("spurious_ready", 64'(READY), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", RESULT, e.res);
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
    return (s && v[31]) ? (-v) : v;
  endfunction

  function automatic int lat_of(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(s, a) < mag(s, b)) return 2;
`endif
    return 33;
  endfunction

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, qq, rr;
    if (b == 0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  // Called just after a rising edge; returns just after the rising edge
  // that ends DONE, with START dropped, so consecutive calls run back-to-back.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res);
    int   lat;
    int   n_stall;
    logic got;
    exp_t e;
    lat        = lat_of(s, a, b);
    START      = 1'b1;
    SIGNED_DIV = s;
    DIVIDEND   = a;
    DIVISOR    = b;
    e.res      = exp_res;
    e.cyc      = cyc + lat;
    sb_q.push_back(e);
    n_stall = 0;
    got     = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (STALL_REQ_EX) n_stall++;
      if (READY) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ready_timeout", 64'(got), 64'd1);
    check("stall_cycles", 64'(n_stall), 64'(lat));
    @(posedge CLK);
    #2;
    START = 1'b0;
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;

    #12;
    check("rst_ready", 64'(READY), 64'd0);
    check("rst_result", RESULT, 64'd0);
    check("rst_stall", 64'(STALL_REQ_EX), 64'd0);
    RST = 1'b1;
    @(posedge CLK);
    #2;

    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    do_div(1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div(1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD});
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    do_div(1'b0, 32'h1234, 32'd0, 64'd0);
    do_div(1'b1, 32'hFFFF_FFF0, 32'd0, 64'd0);
    do_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0});
    do_div(1'b1, -32'sd5, 32'd9, {32'hFFFF_FFFB, 32'd0});
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});

    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 400);
      b = $urandom_range(1, 60);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 1) == 1) b = -b;
      do_div(s, a, b, model(s, a, b));
    end

    // Annul ten cycles into an operation; nothing may be reported for it.
    START      = 1'b1;
    SIGNED_DIV = 1'b0;
    DIVIDEND   = 32'd1000;
    DIVISOR    = 32'd3;
    repeat (10) @(posedge CLK);
    #2;
    ANNUL = 1'b1;
    @(negedge CLK);
    check("annul_stall", 64'(STALL_REQ_EX), 64'd0);
    check("annul_ready", 64'(READY), 64'd0);
    @(posedge CLK);
    #2;
    ANNUL = 1'b0;
    START = 1'b0;
    @(posedge CLK);
    #2;
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Reset in the middle of iterating.
    START      = 1'b1;
    DIVIDEND   = 32'd100;
    DIVISOR    = 32'd7;
    repeat (5) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("rst_on_ready", 64'(READY), 64'd0);
    check("rst_on_result", RESULT, 64'd0);
    START = 1'b0;
    #1;
    check("rst_on_stall", 64'(STALL_REQ_EX), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #2;
    do_div(1'b0, 32'd77, 32'd10, {32'd7, 32'd7});

    // Reset while the result is being presented.
    START    = 1'b1;
    DIVIDEND = 32'd50;
    DIVISOR  = 32'd6;
    begin
      exp_t e;
      e.res = {32'd2, 32'd8};
      e.cyc = cyc + lat_of(1'b0, 32'd50, 32'd6);
      sb_q.push_back(e);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (READY) break;
    end
    #1;
    RST = 1'b0;
    #1;
    check("rst_done_ready", 64'(READY), 64'd0);
    check("rst_done_result", RESULT, 64'd0);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #2;
    do_div(1'b1, -32'sd100, -32'sd7, {32'hFFFF_FFFE, 32'd14});

    repeat (40) @(posedge CLK);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
